// File: rtl/vc_arb_pkg.sv
// Shared types and constants for the VC0/VC1 weighted round-robin arbiter.
package vc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_VC0 = 2'd1,
        SERVE_VC1 = 2'd2
    } arb_state_t;

    localparam int VC_ARB_DW_DEF = 6;
    localparam int CREDIT_W      = 4;

endpackage

// File: rtl/vc_arb_grant.sv
// Combinational grant and next-credit logic for vc_arbiter.
// VC_ARB_STRICT_PRIO_EN selects strict VC0 priority instead of weighted round-robin.
module vc_arb_grant
    import vc_arb_pkg::*;
#(
    parameter int WEIGHT_VC0 = 3
) (
    input  logic                i_vc0_empty,
    input  logic                i_vc1_empty,
    input  logic                i_stall,
    input  logic [CREDIT_W-1:0] i_credit,
    output arb_state_t          o_state,
    output logic                o_vc0_pop,
    output logic                o_vc1_pop,
    output logic [CREDIT_W-1:0] o_credit_nxt
);

`ifdef VC_ARB_STRICT_PRIO_EN
    logic w_unused_credit;
    assign w_unused_credit = ^i_credit;

    always_comb begin
        o_state      = IDLE;
        o_credit_nxt = '0;
        if (!i_stall) begin
            if (!i_vc0_empty)      o_state = SERVE_VC0;
            else if (!i_vc1_empty) o_state = SERVE_VC1;
        end
    end
`else
    localparam logic [CREDIT_W-1:0] W_LIMIT = CREDIT_W'(WEIGHT_VC0);

    always_comb begin
        o_state      = IDLE;
        o_credit_nxt = i_credit;
        if (!i_stall) begin
            if (!i_vc0_empty && (i_vc1_empty || i_credit < W_LIMIT)) o_state = SERVE_VC0;
            else if (!i_vc1_empty)                                   o_state = SERVE_VC1;
            // Credit only counts VC0 grants taken while VC1 is actually waiting.
            if (i_vc1_empty || o_state == SERVE_VC1)
                o_credit_nxt = '0;
            else if (o_state == SERVE_VC0 && i_credit < W_LIMIT)
                o_credit_nxt = i_credit + 1'b1;
        end
    end
`endif

    assign o_vc0_pop = (o_state == SERVE_VC0);
    assign o_vc1_pop = (o_state == SERVE_VC1);

endmodule

// File: rtl/vc_arbiter.sv
// VC0/VC1 arbiter feeding one destination FIFO; pop in cycle N pushes in cycle N+2.
// VC_ARB_STRICT_PRIO_EN selects strict VC0 priority (no credit register).
module vc_arbiter
    import vc_arb_pkg::*;
#(
    parameter int DATA_WIDTH = VC_ARB_DW_DEF,
    parameter int WEIGHT_VC0 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  dest_almost_full,
    input  logic                  dest_full,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic                  push_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  src_vc,
    output logic                  idle
);

    logic                  w_run;
    logic                  w_block;
    logic [CREDIT_W-1:0]   w_credit;
    logic [CREDIT_W-1:0]   w_credit_nxt;
    arb_state_t            w_state_nxt;
    arb_state_t            r_state;
    logic                  w_p1_valid;
    logic                  w_p1_vc1;
    logic                  r_push_out;
    logic                  r_src_vc;
    logic [DATA_WIDTH-1:0] r_data_out;

    assign w_run   = reset & init;
    // Reset is folded into the stall so pops are suppressed while it is held.
    assign w_block = dest_almost_full | dest_full | ~w_run;

    vc_arb_grant #(
        .WEIGHT_VC0(WEIGHT_VC0)
    ) u_grant (
        .i_vc0_empty (vc0_empty),
        .i_vc1_empty (vc1_empty),
        .i_stall     (w_block),
        .i_credit    (w_credit),
        .o_state     (w_state_nxt),
        .o_vc0_pop   (vc0_pop),
        .o_vc1_pop   (vc1_pop),
        .o_credit_nxt(w_credit_nxt)
    );

`ifdef VC_ARB_STRICT_PRIO_EN
    logic w_unused_credit_nxt;
    assign w_unused_credit_nxt = ^w_credit_nxt;
    assign w_credit            = '0;
`else
    logic [CREDIT_W-1:0] r_credit;

    always_ff @(posedge clk) begin
        if (!w_run) r_credit <= '0;
        else        r_credit <= w_credit_nxt;
    end

    assign w_credit = r_credit;
`endif

    // The registered FSM state doubles as pipeline stage p1 (pop valid + source).
    assign w_p1_valid = (r_state != IDLE);
    assign w_p1_vc1   = (r_state == SERVE_VC1);

    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_state    <= IDLE;
            r_push_out <= 1'b0;
            r_data_out <= '0;
            r_src_vc   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_push_out <= w_p1_valid;
            if (w_p1_valid) begin
                r_data_out <= w_p1_vc1 ? vc1_data : vc0_data;
                r_src_vc   <= w_p1_vc1;
            end
        end
    end

    assign push_out = r_push_out;
    assign data_out = r_data_out;
    assign src_vc   = r_src_vc;
    assign idle     = vc0_empty & vc1_empty & ~w_p1_valid & ~r_push_out;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter with behavioural VC FIFOs and a pop/push logger.
module tb_vc_arbiter;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          init = 1'b1;
    logic          dest_almost_full = 1'b0;
    logic          dest_full = 1'b0;
    logic          vc0_empty = 1'b1;
    logic          vc1_empty = 1'b1;
    logic [DW-1:0] vc0_data = '0;
    logic [DW-1:0] vc1_data = '0;
    logic          vc0_pop, vc1_pop, push_out, src_vc, idle;
    logic [DW-1:0] data_out;

    int total = 0;
    int bad   = 0;

    // FIFO models: tasks write mem/wr, the monitor owns rd/data/empty.
    logic [DW-1:0] mem0 [128];
    logic [DW-1:0] mem1 [128];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;

    int            cyc = 0, npop = 0, npush = 0, mon_err = 0;
    logic          pop_vc   [256];
    int            pop_cyc  [256];
    logic [DW-1:0] push_dat [256];
    logic          push_src [256];
    int            push_cyc [256];

    always #5 clk = ~clk;

    vc_arbiter #(.DATA_WIDTH(DW), .WEIGHT_VC0(3)) dut (
        .clk(clk), .reset(reset), .init(init),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .dest_almost_full(dest_almost_full), .dest_full(dest_full),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop), .push_out(push_out),
        .data_out(data_out), .src_vc(src_vc), .idle(idle)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((vc0_pop && vc1_pop) || (vc0_pop && rd0 == wr0) || (vc1_pop && rd1 == wr1))
            mon_err <= mon_err + 1;
        if (vc0_pop) begin
            vc0_data  <= mem0[rd0];
            rd0       <= rd0 + 1;
            vc0_empty <= (rd0 + 1 == wr0);
        end else vc0_empty <= (rd0 == wr0);
        if (vc1_pop) begin
            vc1_data  <= mem1[rd1];
            rd1       <= rd1 + 1;
            vc1_empty <= (rd1 + 1 == wr1);
        end else vc1_empty <= (rd1 == wr1);
        if (vc0_pop || vc1_pop) begin
            pop_vc[npop]  <= vc1_pop;
            pop_cyc[npop] <= cyc;
            npop          <= npop + 1;
        end
        if (push_out) begin
            push_dat[npush] <= data_out;
            push_src[npush] <= src_vc;
            push_cyc[npush] <= cyc;
            npush           <= npush + 1;
        end
    end

    task automatic load(input int vc, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            if (vc == 0) begin mem0[wr0] = DW'(base + i); wr0++; end
            else         begin mem1[wr1] = DW'(base + i); wr1++; end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; init = 1'b1; dest_almost_full = 1'b0; dest_full = 1'b0;
        wr0 = rd0; wr1 = rd1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (idle !== 1'b1 || push_out !== 1'b0 || data_out !== '0) begin
            bad++; $display("FAIL reset_state idle=%b push=%b data=%h want 1/0/00", idle, push_out, data_out);
        end
        load(0, 2, 6'h01); load(1, 2, 6'h02);
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({vc0_pop, vc1_pop, push_out} !== 3'b000 || data_out !== '0 || idle !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold pops=%b%b push=%b data=%h idle=%b want 00/0/00/0",
                         vc0_pop, vc1_pop, push_out, data_out, idle);
            end
        end
        do_reset();
    endtask

    task automatic test_vc0_only();
        int b, bp;
        b = npop; bp = npush;
        load(0, 4, 6'h11);
        repeat (10) @(negedge clk);
        total++;
        if (npop - b != 4 || npush - bp != 4) begin
            bad++; $display("FAIL vc0_only counts pops=%0d pushes=%0d want 4/4", npop - b, npush - bp);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (pop_vc[b+i] !== 1'b0 || pop_cyc[b+i] != pop_cyc[b] + i ||
                    push_dat[bp+i] !== DW'(6'h11 + i) || push_src[bp+i] !== 1'b0 ||
                    push_cyc[bp+i] != pop_cyc[b] + 2 + i) begin
                    bad++;
                    $display("FAIL vc0_only word%0d data=%h src=%b lat=%0d want %h/0/%0d", i,
                             push_dat[bp+i], push_src[bp+i], push_cyc[bp+i] - pop_cyc[b], 6'h11 + i, 2 + i);
                end
            end
        end
        total++;
        if (idle !== 1'b1) begin bad++; $display("FAIL vc0_only idle=%b want 1", idle); end
    endtask

    task automatic test_wrr();
        int b, bp, c0, c1;
        logic [15:0] seq;
        seq = 16'b0001_0001_0011_1111;
        do_reset();
        b = npop; bp = npush; c0 = 0; c1 = 0;
        load(0, 8, 6'h20); load(1, 8, 6'h30);
        repeat (24) @(negedge clk);
        total++;
        if (npop - b != 16 || npush - bp != 16) begin
            bad++; $display("FAIL wrr counts pops=%0d pushes=%0d want 16/16", npop - b, npush - bp);
        end else begin
            for (int i = 0; i < 16; i++) begin
                logic [DW-1:0] want;
                want = seq[15-i] ? DW'(6'h30 + c1) : DW'(6'h20 + c0);
                if (seq[15-i]) c1++; else c0++;
                total++;
                if (pop_vc[b+i] !== seq[15-i] || pop_cyc[b+i] != pop_cyc[b] + i ||
                    push_dat[bp+i] !== want || push_src[bp+i] !== seq[15-i]) begin
                    bad++;
                    $display("FAIL wrr slot%0d pop=%b data=%h src=%b want %b/%h/%b", i,
                             pop_vc[b+i], push_dat[bp+i], push_src[bp+i], seq[15-i], want, seq[15-i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int b, pb;
        logic [15:0] seq;
        seq = 16'b0001_0001_0011_1111;
        do_reset();
        b = npop;
        load(0, 8, 6'h20); load(1, 8, 6'h30);
        repeat (3) @(negedge clk);
        dest_almost_full = 1'b1;
        #1;
        total++;
        if ({vc0_pop, vc1_pop} !== 2'b00 || npop - b != 2) begin
            bad++; $display("FAIL stall_rise pops=%b%b popped=%0d want 00/2", vc0_pop, vc1_pop, npop - b);
        end
        pb = npush;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) begin dest_almost_full = 1'b0; dest_full = 1'b1; end
            #1;
            total++;
            if ({vc0_pop, vc1_pop} !== 2'b00) begin
                bad++; $display("FAIL stall_hold%0d pops=%b%b want 00", k, vc0_pop, vc1_pop);
            end
        end
        total++;
        if (npush - pb != 2 || npop - b != 2) begin
            bad++; $display("FAIL stall_drain pushes=%0d pops=%0d want 2/2", npush - pb, npop - b);
        end
        dest_full = 1'b0;
        #1;
        total++;
        if ({vc0_pop, vc1_pop} !== 2'b10) begin
            bad++; $display("FAIL stall_resume pops=%b%b want 10", vc0_pop, vc1_pop);
        end
        repeat (24) @(negedge clk);
        total++;
        if (npop - b != 16) begin
            bad++; $display("FAIL stall_total pops=%0d want 16", npop - b);
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (pop_vc[b+i] !== seq[15-i]) begin
                    bad++; $display("FAIL stall_seq slot%0d pop=%b want %b", i, pop_vc[b+i], seq[15-i]);
                end
            end
        end
    endtask

    task automatic test_init();
        int b, bp, bi, bpi;
        logic [4:0]  pre;
        logic [10:0] seq;
        pre = 5'b00010;
        seq = 11'b00010111111;
        do_reset();
        b = npop; bp = npush;
        load(0, 8, 6'h20); load(1, 8, 6'h30);
        repeat (6) @(negedge clk);
        total++;
        if (npop - b != 5 || {pop_vc[b], pop_vc[b+1], pop_vc[b+2], pop_vc[b+3], pop_vc[b+4]} !== pre) begin
            bad++; $display("FAIL init_pre pops=%0d want 5 in order 00010", npop - b);
        end
        init = 1'b0;
        #1;
        total++;
        if ({vc0_pop, vc1_pop} !== 2'b00) begin
            bad++; $display("FAIL init_pops pops=%b%b want 00", vc0_pop, vc1_pop);
        end
        @(negedge clk);
        total++;
        if (push_out !== 1'b0 || npush - bp != 4) begin
            bad++; $display("FAIL init_flush push=%b pushed=%0d want 0/4", push_out, npush - bp);
        end
        init = 1'b1;
        bi = npop; bpi = npush;
        repeat (20) @(negedge clk);
        total++;
        if (npop - bi != 11 || npush - bpi != 11) begin
            bad++; $display("FAIL init_restart pops=%0d pushes=%0d want 11/11", npop - bi, npush - bpi);
        end else begin
            for (int i = 0; i < 11; i++) begin
                total++;
                if (pop_vc[bi+i] !== seq[10-i]) begin
                    bad++; $display("FAIL init_seq slot%0d pop=%b want %b", i, pop_vc[bi+i], seq[10-i]);
                end
            end
            total++;
            if (push_dat[bpi] !== 6'h24 || push_src[bpi] !== 1'b0) begin
                bad++; $display("FAIL init_first data=%h src=%b want 24/0", push_dat[bpi], push_src[bpi]);
            end
        end
    endtask

    task automatic test_strict_prio();
        int b;
        do_reset();
        b = npop;
        load(0, 5, 6'h20); load(1, 5, 6'h30);
        repeat (16) @(negedge clk);
        total++;
        if (npop - b != 10) begin
            bad++; $display("FAIL strict counts pops=%0d want 10", npop - b);
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (pop_vc[b+i] !== (i >= 5)) begin
                    bad++; $display("FAIL strict slot%0d pop=%b want %b", i, pop_vc[b+i], i >= 5);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vc0_only();
`ifdef VC_ARB_STRICT_PRIO_EN
        test_strict_prio();
`else
        test_wrr();
        test_stall();
        test_init();
`endif
        total++;
        if (mon_err !== 0) begin
            bad++; $display("FAIL protocol violations=%0d want 0", mon_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Weighted round-robin arbiter between the VC0 and VC1 virtual-channel FIFOs of the PCIe transmit layer. It sits downstream of both VC FIFOs and drives their `rd_enable` inputs. It forwards the popped words into a single downstream FIFO. It holds off when that destination reports almost-full, so no word is ever lost or popped from an empty FIFO.

## Interface
- `DATA_WIDTH`, 6: word width of VC FIFOs and destination.
- `WEIGHT_VC0`, 3: consecutive VC0 grants allowed while VC1 is waiting (legal range 1..15).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `init`  in  1  active-low synchronous clear; same effect as `reset`.
- `vc0_empty`, `vc1_empty`  in  1  empty flags of the VC FIFOs.
- `vc0_data`, `vc1_data`  in  DATA_WIDTH  VC FIFO read data; valid the cycle after its pop.
- `dest_almost_full`, `dest_full`  in  1  destination FIFO status.
- `vc0_pop`, `vc1_pop`  out  1  read enables to the VC FIFOs; combinational, never both high.
- `push_out`  out  1  registered write enable to the destination.
- `data_out`  out  DATA_WIDTH  registered word for the destination.
- `src_vc`  out  1  registered; source of the current `push_out` word (0 = VC0).
- `idle`  out  1  high when both VCs are empty and no word is in flight.

## Operation
- `stall = dest_almost_full | dest_full`. When stall is high, both pops are low.
- FSM states:
  - IDLE: no pop this cycle.
  - SERVE_VC0: `vc0_pop` high this cycle.
  - SERVE_VC1: `vc1_pop` high this cycle.
  - The state is re-evaluated every cycle from current inputs and the credit register.
- Grant rule (when not stalled):
  - Both VCs empty: go to IDLE.
  - Only VC0 non-empty: pop VC0.
  - Only VC1 non-empty: pop VC1.
  - Both non-empty and `credit < WEIGHT_VC0`: pop VC0.
  - Both non-empty and `credit == WEIGHT_VC0`: pop VC1.
- Credit register, 4 bits:
  - Increments on a VC0 pop while VC1 is non-empty.
  - Clears on any VC1 pop, or whenever VC1 is empty.
  - Held while stalled.
  - Never exceeds `WEIGHT_VC0`.
- Two-stage in-flight pipeline, stages p1 and p2:
  - p1 captures pop-valid and the source VC.
  - In the next cycle, p2 loads `data_out` from the selected `vcX_data`, sets `push_out` and sets `src_vc`.
- Emptiness: pops are qualified only by the current empty flags. The VC FIFO count updates on the pop edge, so back-to-back pops are safe.
- `idle` = `vc0_empty & vc1_empty & ~p1_valid & ~push_out`.

## Timing
- Reset (`reset==0` or `init==0`, sampled at the clock edge):
  - State goes to IDLE; credit and the p1 valid go to 0.
  - `push_out`=0, `data_out`=0, `src_vc`=0.
  - Pops are 0 while `reset` or `init` is low.
  - In-flight words are discarded.
- Latency: a pop in cycle N gives `push_out`/`data_out` valid in cycle N+2. Throughput is one word per cycle.
- Stall: a pop drops in the same cycle `dest_almost_full` rises. Up to 2 words already in flight still push. The destination almost-full threshold must therefore leave at least 2 free entries.
- Simultaneous events:
  - Stall dominates arbitration.
  - Reset dominates everything.
  - `dest_full` does not block in-flight pushes, because the threshold rule guarantees space.
- Credit wrap: cannot occur, because the counter saturates at `WEIGHT_VC0`.

## Configuration
- `VC_ARB_STRICT_PRIO_EN` defined:
  - Strict priority: VC0 is popped whenever it is non-empty and there is no stall.
  - VC1 is popped only when VC0 is empty.
  - The credit register is not built; `WEIGHT_VC0` is ignored.
- Not defined: the weighted round-robin described above.

## Structure
- Shared package `vc_arb_pkg` holds:
  - State encoding (IDLE=2'd0, SERVE_VC0=2'd1, SERVE_VC1=2'd2).
  - Default `DATA_WIDTH` and credit width constants.
- Sub-module `vc_arb_grant`: purely combinational grant/next-credit logic. It takes the empties, stall and credit, and returns the pops and the next credit. The parent holds the FSM register and the p1/p2 pipeline.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with both VCs non-empty. Required: pops=0, `push_out`=0, `data_out`=0, `idle` follows the empties.
- VC0 only: load 4 words (0x11..0x14), VC1 empty. Required: `vc0_pop` high for 4 cycles; `push_out` high for 4 cycles starting 2 cycles after the first pop; data 0x11..0x14 in order with `src_vc`=0.
- Both VCs loaded with 8 words, `WEIGHT_VC0`=3. Required pop sequence: 0,0,0,1,0,0,0,1,… until one VC drains, then the other VC is popped continuously.
- Raise `dest_almost_full` mid-burst. Required: pops are 0 in the same cycle, exactly 2 more pushes occur, pops resume the cycle after deassert, and the credit value is preserved.
- Pull `init` low for 1 cycle mid-burst. Required: pops are 0 that cycle, `push_out`=0 the next cycle, credit=0, and arbitration restarts with VC0 when both are non-empty.
- With `VC_ARB_STRICT_PRIO_EN`, both VCs loaded with 5 words. Required: 5 VC0 pops, then 5 VC1 pops.
